// File: rtl/conv_window_seq_pkg.sv
// conv_window_seq_pkg -- shared definitions for the convolution window sequencer.
//   state_t    : sequencer FSM states (IDLE, STREAM, DONE)
//   STALL_W    : width of the optional stall counter
//   win_count(): number of output windows a frame of the given geometry yields
package conv_window_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int STALL_W = 32;

    // Windows per frame: one per stride step in each dimension.
    function automatic int win_count(input int img_h, input int img_w,
                                     input int k, input int stride);
        return ((img_h - k) / stride + 1) * ((img_w - k) / stride + 1);
    endfunction

endpackage

// File: rtl/conv_window_seq_win_pos_counter.sv
// win_pos_counter -- raster row/column tracker with stride-phase window detection.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : synchronous clear back to row 0 / column 0
//   adv             : advance one pixel position (one accepted pixel)
//   last            : current position is the final pixel of the frame
//   win_hit         : the pixel at the current position completes a window
//   win_row/win_col : top-left coordinate of that window (0 when no hit)
// The stride phase of each axis is tracked incrementally instead of computing
// (pos-K+1) % STRIDE, so no divider is needed for non-power-of-two strides.
module win_pos_counter
    import conv_window_seq_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic             last,
    output logic             win_hit,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col
);

    localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_K1   = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);

    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic [PH_W-1:0]  row_ph_r;
    logic [PH_W-1:0]  col_ph_r;
    logic [PH_W-1:0]  row_ph_nxt_s;
    logic [PH_W-1:0]  col_ph_nxt_s;

    // Phase of the next position: stays 0 until the axis reaches K-1, then
    // cycles 0..STRIDE-1 so that phase 0 marks a window-aligned position.
    always_comb begin
        row_ph_nxt_s = '0;
        col_ph_nxt_s = '0;
        if (row_r >= ROW_K1) begin
            row_ph_nxt_s = (row_ph_r == PH_LAST) ? '0 : row_ph_r + PH_ONE;
        end else begin
            row_ph_nxt_s = '0;
        end
        if (col_r >= COL_K1) begin
            col_ph_nxt_s = (col_ph_r == PH_LAST) ? '0 : col_ph_r + PH_ONE;
        end else begin
            col_ph_nxt_s = '0;
        end
    end

    // Position registers: column steps per pixel, row steps on column wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_r    <= '0;
            col_r    <= '0;
            row_ph_r <= '0;
            col_ph_r <= '0;
        end else if (adv) begin
            if (col_r == COL_LAST) begin
                col_r    <= '0;
                col_ph_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r    <= '0;
                    row_ph_r <= '0;
                end else begin
                    row_r    <= row_r + ROW_ONE;
                    row_ph_r <= row_ph_nxt_s;
                end
            end else begin
                col_r    <= col_r + COL_ONE;
                col_ph_r <= col_ph_nxt_s;
            end
        end
    end

    assign last = (row_r == ROW_LAST) && (col_r == COL_LAST);

    // Window detection for the pixel sitting at the current position.
    always_comb begin
        win_hit = 1'b0;
        win_row = '0;
        win_col = '0;
        if ((row_r >= ROW_K1) && (col_r >= COL_K1) &&
            (row_ph_r == '0) && (col_ph_r == '0)) begin
            win_hit = 1'b1;
            win_row = row_r - ROW_K1;
            win_col = col_r - COL_K1;
        end else begin
            win_hit = 1'b0;
            win_row = '0;
            win_col = '0;
        end
    end

endmodule

// File: rtl/conv_window_seq.sv
// conv_window_seq -- sequences a raster pixel stream into K-row line buffers and
// flags which line-buffer pushes complete a KxK convolution window.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : frame start pulse (ignored while busy)
//   in_valid/in_ready   : pixel handshake, in_data is the raster-order pixel
//   out_ready           : downstream can take a push (gates in_ready)
//   lb_push/lb_data     : registered line-buffer shift strobe and pixel
//   win_valid           : current lb_push completes a window
//   win_row/win_col     : window top-left coordinate (0 unless win_valid)
//   busy                : frame in progress (STREAM or DONE)
//   done                : one-cycle end-of-frame pulse
//   stall_cnt           : (CONV_WIN_PERF_EN only) STREAM cycles with in_valid
//                         high and out_ready low, saturating
// Optional build macro: CONV_WIN_PERF_EN adds the stall counter.
module conv_window_seq
    import conv_window_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     out_ready,
    output logic                     lb_push,
    output logic [DATA_W-1:0]        lb_data,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     busy,
    output logic                     done
`ifdef CONV_WIN_PERF_EN
    ,
    output logic [STALL_W-1:0]       stall_cnt
`endif
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    state_t           state_r;
    state_t           state_nxt;
    logic             accept_s;
    logic             clr_s;
    logic             last_s;
    logic             hit_s;
    logic [ROW_W-1:0] hit_row_s;
    logic [COL_W-1:0] hit_col_s;

    logic              lb_push_r;
    logic [DATA_W-1:0] lb_data_r;
    logic              win_valid_r;
    logic [ROW_W-1:0]  win_row_r;
    logic [COL_W-1:0]  win_col_r;
    logic              done_r;

    assign in_ready = (state_r == ST_STREAM) && out_ready;
    assign accept_s = in_valid && in_ready;
    assign busy     = (state_r != ST_IDLE);

    win_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .STRIDE (STRIDE),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .adv     (accept_s),
        .last    (last_s),
        .win_hit (hit_s),
        .win_row (hit_row_s),
        .win_col (hit_col_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next state; start only matters in IDLE, so a start during a frame
    // (including one coincident with the final pixel) never clears counters.
    always_comb begin
        state_nxt = state_r;
        clr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_STREAM;
                    clr_s     = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && last_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered line-buffer and window outputs, one cycle after acceptance;
    // done fires in the cycle after the DONE state (i.e. after the last push).
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_push_r   <= 1'b0;
            lb_data_r   <= '0;
            win_valid_r <= 1'b0;
            win_row_r   <= '0;
            win_col_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            lb_push_r   <= accept_s;
            if (accept_s) begin
                lb_data_r <= in_data;
            end
            win_valid_r <= accept_s && hit_s;
            win_row_r   <= (accept_s && hit_s) ? hit_row_s : '0;
            win_col_r   <= (accept_s && hit_s) ? hit_col_s : '0;
            done_r      <= (state_r == ST_DONE);
        end
    end

    assign lb_push   = lb_push_r;
    assign lb_data   = lb_data_r;
    assign win_valid = win_valid_r;
    assign win_row   = win_row_r;
    assign win_col   = win_col_r;
    assign done      = done_r;

`ifdef CONV_WIN_PERF_EN
    logic [STALL_W-1:0] stall_cnt_r;

    // Backpressure stall counter, cleared at frame start, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && start) begin
            stall_cnt_r <= '0;
        end else if ((state_r == ST_STREAM) && in_valid && !out_ready &&
                     (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/conv_window_seq.md
CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, pixel width.
REQ-002 SHALL have parameter IMG_W, default 8, frame width in pixels (>= K).
REQ-003 SHALL have parameter IMG_H, default 8, frame height in rows (>= K).
REQ-004 SHALL have parameter K, default 3, kernel size, equal to row line-buffer depth.
REQ-005 SHALL have parameter STRIDE, default 1, window stride (1..K).
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  frame start pulse.
REQ-009 SHALL have port in_valid  input  1  pixel valid.
REQ-010 SHALL have port in_ready  output  1  pixel accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port in_data  input  DATA_W  pixel, raster order.
REQ-012 SHALL have port out_ready  input  1  downstream convolution stage can take a push.
REQ-013 SHALL have port lb_push  output  1  shift strobe to the line buffers.
REQ-014 SHALL have port lb_data  output  DATA_W  pixel to the line buffers.
REQ-015 SHALL have port win_valid  output  1  current lb_push completes an output window.
REQ-016 SHALL have ports win_row and win_col  output  $clog2(IMG_H) and $clog2(IMG_W)  top-left coordinate of that window.
REQ-017 SHALL have port busy  output  1  frame in progress.
REQ-018 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement FSM IDLE -> STREAM -> DONE -> IDLE.
REQ-020 IDLE: start=1 SHALL go to STREAM and clear the row and column counters.
REQ-021 In STREAM, in_ready SHALL equal out_ready; in IDLE and DONE, in_ready SHALL be 0.
REQ-022 Each accepted pixel SHALL produce lb_push=1 with lb_data=in_data on the next cycle (latency 1); lb_push SHALL otherwise be 0.
REQ-023 The column counter SHALL increment per accepted pixel and wrap to 0 after IMG_W-1, at which point the row counter SHALL increment.
REQ-024 win_valid SHALL be asserted with lb_push iff, for the pushed pixel, row>=K-1, col>=K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
REQ-025 win_row SHALL be row-K+1 and win_col SHALL be col-K+1 when win_valid=1, and 0 otherwise.
REQ-026 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL go to DONE, and done SHALL pulse the cycle after that final lb_push.
REQ-027 start SHALL be ignored while busy=1, including a start coincident with the final pixel.
REQ-028 busy SHALL be 1 in STREAM and DONE.
REQ-029 Total win_valid pulses per frame SHALL equal ((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1).

Reset
REQ-030 rst SHALL take priority over all inputs and force IDLE, clear both counters, and clear lb_push, win_valid, win_row, win_col, busy, done and lb_data.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next start SHALL begin again at row 0, column 0.

Configuration
REQ-032 With macro CONV_WIN_PERF_EN defined, the block SHALL add output stall_cnt (32 bits), counting STREAM cycles with in_valid=1 and out_ready=0, cleared by rst and at start, and saturating at all-ones.
REQ-033 Without CONV_WIN_PERF_EN, stall_cnt and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef (IDLE, STREAM, DONE) and the window-count helper function.
REQ-035 Row/column counting with the stride-phase check SHALL be one sub-module, win_pos_counter, instantiated once.

Verification
REQ-036 IMG 4x4, K=3, STRIDE=1, 16 pixels with out_ready=1 -> 4 win_valid pulses at (0,0),(0,1),(1,0),(1,1), done at cycle 17 after the first acceptance.
REQ-037 IMG 5x5, K=3, STRIDE=2 -> exactly 4 win_valid pulses at (0,0),(0,2),(2,0),(2,2).
REQ-038 out_ready held 0 for 5 cycles mid-row -> in_ready=0, no lb_push, counters frozen, stall_cnt=5 with CONV_WIN_PERF_EN.
REQ-039 start pulsed again during STREAM and on the final pixel -> no counter clear, single done.
REQ-040 rst asserted after 7 pixels, then start -> first lb_push is treated as row 0, col 0, and the full window sequence repeats.
